serial_pattern_scan_ctrl: RTL
=============================

Name: serial_pattern_scan_ctrl

Overview:
- Word-level controller for the serial bit-pattern detector.
- Accepts a parallel word over a valid/ready handshake and serializes it MSB-first into an internal overlapping pattern detector.
- The detector pattern is programmable. The block counts matches per word and reports completion with a one-cycle Done pulse.
- Sits between a parallel producer and the serial detection datapath; it sequences and configures that datapath.

Parameters:
W, 16, data word width (>= PW)
PW, 4, pattern length in bits
CW, 5, match counter width; counter saturates at 2^CW-1
RST_PAT, 4'b0101, pattern register value after reset (PW bits)

Ports:
CP  input  1  clock, rising edge
CR  input  1  asynchronous reset, active-high
Cfg_We  input  1  pattern write strobe
Cfg_Pat  input  PW  new pattern value
Keep_Hist  input  1  1 = detector history carries over from previous word; sampled at accept
In_Valid  input  1  word available
In_Data  input  W  word to scan
In_Ready  output  1  block can accept a word (state IDLE)
Busy  output  1  state SHIFT or DONE
Sout  output  1  bit being fed to detector this cycle (MSB of shift reg in SHIFT, else 0)
Match  output  1  registered pulse, 1 cycle per detected occurrence
Done  output  1  one-cycle pulse, scan of word finished
Match_Cnt  output  CW  matches in last/current word, held until next accept
Hit  output  1  Match_Cnt != 0

Behaviour:
- Reset (CR=1, async):
  - state=IDLE; pattern=RST_PAT; history and seen-count cleared.
  - Match=0, Done=0, Match_Cnt=0, Hit=0, Sout=0, Busy=0, In_Ready=1.
- States: IDLE -> SHIFT -> DONE -> IDLE.
- IDLE:
  - In_Ready=1.
  - Accept on rising edge E with In_Valid=1: shift reg<=In_Data, bit counter<=0, Match_Cnt<=0, next state SHIFT.
  - If Keep_Hist=0 at accept, history and seen-count are cleared.
- SHIFT:
  - At each edge E+1..E+W one bit (MSB first) enters the detector.
  - history<={history[PW-2:0],bit}; seen-count increments, saturating at PW.
- Match detection:
  - Match<=1 at the edge where the new history equals the pattern AND seen>=PW; otherwise Match<=0.
  - Detection is overlapping; Match_Cnt increments on the same edge and saturates.
- After edge E+W:
  - state=DONE, Done=1 for exactly one cycle, Match_Cnt final.
  - Edge E+W+1 returns to IDLE.
  - Throughput: one word per W+2 cycles.
- Cfg_We:
  - Honoured only in IDLE. Writes the pattern and clears history and seen-count.
  - Ignored (no effect) in SHIFT/DONE.
  - Cfg_We and accept in the same IDLE cycle: the new pattern applies to that word, and history is cleared regardless of Keep_Hist.
- In_Valid while not IDLE is ignored; the word is not consumed (In_Ready=0).
- Reset asserted mid-SHIFT: word is aborted, no Done pulse, all state returns to reset values.

Test Plan:
- Reset, default pattern 0101, accept 16'h5555 with Keep_Hist=0 -> Match pulses at shift edges 4,6,8,10,12,14,16; Match_Cnt=7; Done high at cycle E+W; In_Ready high again at E+W+1.
- Accept 16'hA5A5, Keep_Hist=0 -> Match at shift edges 8 and 16; Match_Cnt=2; Hit=1.
- Accept 16'h0001, then 16'h4000 with Keep_Hist=1 -> second word Match at its shift edge 2, Match_Cnt=1. Repeat with Keep_Hist=0 -> Match_Cnt=0, Hit=0.
- Cfg_We=1 with Cfg_Pat=4'b1111 in IDLE, accept 16'hFFFF -> Match_Cnt=13. Cfg_We pulse during SHIFT -> pattern unchanged.
- Build with CW=2, accept 16'h5555 -> Match_Cnt saturates at 3, Match still pulses 7 times.
- Assert CR at shift edge 5 of 16'h5555 -> no Done; Match_Cnt=0; pattern=0101; In_Ready=1 immediately; next word scans normally.

Source files
------------

// File: rtl/serial_pattern_scan_ctrl_if.sv
// Word, configuration and status bundle for the serial pattern scan controller.
interface serial_pattern_scan_ctrl_if #(
    parameter int unsigned W  = 16,
    parameter int unsigned PW = 4,
    parameter int unsigned CW = 5
);
    logic          Cfg_We;
    logic [PW-1:0] Cfg_Pat;
    logic          Keep_Hist;
    logic          In_Valid;
    logic [W-1:0]  In_Data;
    logic          In_Ready;
    logic          Busy;
    logic          Sout;
    logic          Match;
    logic          Done;
    logic [CW-1:0] Match_Cnt;
    logic          Hit;

    // Producer side: drives words and configuration, observes status.
    modport master (
        output Cfg_We, Cfg_Pat, Keep_Hist, In_Valid, In_Data,
        input  In_Ready, Busy, Sout, Match, Done, Match_Cnt, Hit
    );

    // Controller side.
    modport slave (
        input  Cfg_We, Cfg_Pat, Keep_Hist, In_Valid, In_Data,
        output In_Ready, Busy, Sout, Match, Done, Match_Cnt, Hit
    );
endinterface

// File: rtl/serial_pattern_scan_ctrl.sv
// Serializes accepted words MSB-first into an overlapping pattern detector and counts matches per word.
module serial_pattern_scan_ctrl #(
    parameter int unsigned   W       = 16,
    parameter int unsigned   PW      = 4,
    parameter int unsigned   CW      = 5,
    parameter logic [PW-1:0] RST_PAT = PW'(4'b0101)
) (
    input  logic                        CP,
    input  logic                        CR,
    serial_pattern_scan_ctrl_if.slave   bus
);

    localparam int unsigned BCW = (W > 1) ? $clog2(W) : 1;
    localparam int unsigned SCW = $clog2(PW + 1);
    localparam logic [CW-1:0]  CNT_MAX  = {CW{1'b1}};
    localparam logic [SCW-1:0] SEEN_MAX = SCW'(PW);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [PW-1:0]  pat_q, pat_d;
    logic [PW-1:0]  hist_q, hist_d, hist_nxt;
    logic [SCW-1:0] seen_q, seen_d, seen_nxt;
    logic [W-1:0]   shreg_q, shreg_d;
    logic [BCW-1:0] bcnt_q, bcnt_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           match_q, match_d;
    logic           done_q, done_d;
    logic           sout_q, sout_d;
    logic           hit_q, hit_d;
    logic           in_ready_q, in_ready_d;
    logic           busy_q, busy_d;

    // State and datapath registers.
    always_ff @(posedge CP or posedge CR) begin
        if (CR) begin
            state_q    <= S_IDLE;
            pat_q      <= RST_PAT;
            hist_q     <= '0;
            seen_q     <= '0;
            shreg_q    <= '0;
            bcnt_q     <= '0;
            cnt_q      <= '0;
            match_q    <= 1'b0;
            done_q     <= 1'b0;
            sout_q     <= 1'b0;
            hit_q      <= 1'b0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pat_q      <= pat_d;
            hist_q     <= hist_d;
            seen_q     <= seen_d;
            shreg_q    <= shreg_d;
            bcnt_q     <= bcnt_d;
            cnt_q      <= cnt_d;
            match_q    <= match_d;
            done_q     <= done_d;
            sout_q     <= sout_d;
            hit_q      <= hit_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state, detector update and registered output values.
    always_comb begin
        state_d  = state_q;
        pat_d    = pat_q;
        hist_d   = hist_q;
        seen_d   = seen_q;
        shreg_d  = shreg_q;
        bcnt_d   = bcnt_q;
        cnt_d    = cnt_q;
        match_d  = 1'b0;
        done_d   = 1'b0;
        hist_nxt = {hist_q[PW-2:0], shreg_q[W-1]};
        seen_nxt = (seen_q == SEEN_MAX) ? seen_q : seen_q + SCW'(1);

        unique case (state_q)
            S_IDLE: begin
                // A pattern write always restarts the detector history.
                if (bus.Cfg_We) begin
                    pat_d  = bus.Cfg_Pat;
                    hist_d = '0;
                    seen_d = '0;
                end
                if (bus.In_Valid) begin
                    shreg_d = bus.In_Data;
                    bcnt_d  = '0;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                    if (!bus.Keep_Hist) begin
                        hist_d = '0;
                        seen_d = '0;
                    end
                end
            end
            S_SHIFT: begin
                hist_d  = hist_nxt;
                seen_d  = seen_nxt;
                shreg_d = {shreg_q[W-2:0], 1'b0};
                bcnt_d  = bcnt_q + BCW'(1);
                if ((hist_nxt == pat_q) && (seen_nxt >= SEEN_MAX)) begin
                    match_d = 1'b1;
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                if (bcnt_q == LAST_BIT) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        in_ready_d = (state_d == S_IDLE);
        busy_d     = (state_d != S_IDLE);
        sout_d     = (state_d == S_SHIFT) ? shreg_d[W-1] : 1'b0;
        hit_d      = (cnt_d != '0);
    end

    assign bus.In_Ready  = in_ready_q;
    assign bus.Busy      = busy_q;
    assign bus.Sout      = sout_q;
    assign bus.Match     = match_q;
    assign bus.Done      = done_q;
    assign bus.Match_Cnt = cnt_q;
    assign bus.Hit       = hit_q;

endmodule
